// File: rtl/vred_seq_ctrl_if.sv
// Bundles the word-in stream, reduction-unit issue/result bus and scalar-out stream.
// slave is the sequencer side; master is the upstream/datapath/consumer side.
interface vred_seq_ctrl_if #(
  parameter int REQ_DATA_WIDTH  = 32,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int OPSEL_WIDTH     = 9,
  parameter int SEW_WIDTH       = 2
);
  logic                        in_valid;
  logic [REQ_DATA_WIDTH-1:0]   in_data;
  logic                        in_last;
  logic [SEW_WIDTH-1:0]        in_sew;
  logic [OPSEL_WIDTH-1:0]      in_opSel;
  logic                        in_ready;
  logic [2*REQ_DATA_WIDTH-1:0] red_vec0;
  logic                        red_en;
  logic [SEW_WIDTH-1:0]        red_sew;
  logic [OPSEL_WIDTH-1:0]      red_opSel;
  logic [RESP_DATA_WIDTH-1:0]  red_result;
  logic                        out_valid;
  logic [REQ_DATA_WIDTH-1:0]   out_data;
  logic                        out_ready;

  modport slave (
    input  in_valid, in_data, in_last, in_sew, in_opSel,
    output in_ready,
    output red_vec0, red_en, red_sew, red_opSel,
    input  red_result,
    output out_valid, out_data,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_last, in_sew, in_opSel,
    input  in_ready,
    input  red_vec0, red_en, red_sew, red_opSel,
    output red_result,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/vred_seq_ctrl.sv
// Sequences word accumulation and lane folding through an external reduction datapath.
// RED_LATENCY+1 cycles per word/fold; input stalls outside IDLE/ACCUM, result holds until out_ready.
module vred_seq_ctrl #(
  parameter int REQ_DATA_WIDTH  = 32,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int OPSEL_WIDTH     = 9,
  parameter int SEW_WIDTH       = 2,
  parameter int RED_LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  vred_seq_ctrl_if.slave   bus
);
  localparam int DW = REQ_DATA_WIDTH;
  localparam int IW = $clog2(DW);
  localparam int WW = IW + 1;
  localparam int CW = (RED_LATENCY < 2) ? 1 : $clog2(RED_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_WAIT, S_FOLD, S_FWAIT, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          acc_q, acc_d;
  logic [2*DW-1:0]        vec_q, vec_d;
  logic                   en_q, en_d;
  logic [SEW_WIDTH-1:0]   sew_q, sew_d;
  logic [OPSEL_WIDTH-1:0] op_q, op_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic [WW-1:0]          fold_w_q, fold_w_d;
  logic                   ov_q, ov_d;
  logic [DW-1:0]          od_q, od_d;

  logic                   in_ready;
  logic                   accept;
  logic [DW-1:0]          acc_hi, rep, sew_mask;
  logic [IW-1:0]          fold_mask, idx;
  logic [7:0]             sew_bits;
  logic                   unused_res;

  assign in_ready   = !rst && (state_q == S_IDLE || state_q == S_ACCUM);
  assign accept     = bus.in_valid && in_ready;
  assign unused_res = ^bus.red_result;

  // Lanes of width SEW: upper half of the active window is replicated across the operand.
  assign acc_hi    = acc_q >> fold_w_q;
  assign fold_mask = IW'(fold_w_q - WW'(1));
  always_comb begin
    rep = '0;
    idx = '0;
    for (int i = 0; i < DW; i++) begin
      idx    = IW'(i) & fold_mask;
      rep[i] = acc_hi[idx];
    end
  end

  always_comb begin
    sew_bits = 8'd32;
    sew_mask = '1;
    case (sew_q)
      2'd0:    begin sew_bits = 8'd8;  sew_mask = DW'(8'hFF);   end
      2'd1:    begin sew_bits = 8'd16; sew_mask = DW'(16'hFFFF); end
      default: begin sew_bits = 8'd32; sew_mask = '1;            end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    vec_d    = vec_q;
    en_d     = 1'b0;
    sew_d    = sew_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    fold_w_d = fold_w_q;
    ov_d     = ov_q;
    od_d     = od_q;
    case (state_q)
      S_IDLE: if (accept) begin
        acc_d    = bus.in_data;
        sew_d    = bus.in_sew;
        op_d     = bus.in_opSel;
        fold_w_d = WW'(DW / 2);
        state_d  = bus.in_last ? S_FOLD : S_ACCUM;
      end
      S_ACCUM: if (accept) begin
        vec_d   = {bus.in_data, acc_q};
        en_d    = 1'b1;
        cnt_d   = CW'(RED_LATENCY);
        last_d  = bus.in_last;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          acc_d   = bus.red_result[DW-1:0];
          state_d = last_q ? S_FOLD : S_ACCUM;
        end
      end
      S_FOLD: begin
        if (8'(fold_w_q) < sew_bits) begin
          ov_d    = 1'b1;
          od_d    = acc_q & sew_mask;
          state_d = S_DONE;
        end else begin
          vec_d   = {rep, acc_q};
          en_d    = 1'b1;
          cnt_d   = CW'(RED_LATENCY);
          state_d = S_FWAIT;
        end
      end
      S_FWAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          acc_d    = bus.red_result[DW-1:0];
          fold_w_d = fold_w_q >> 1;
          state_d  = S_FOLD;
        end
      end
      S_DONE: if (bus.out_ready) begin
        ov_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      vec_q    <= '0;
      en_q     <= 1'b0;
      sew_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      fold_w_q <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      vec_q    <= vec_d;
      en_q     <= en_d;
      sew_q    <= sew_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      fold_w_q <= fold_w_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.red_vec0  = vec_q;
  assign bus.red_en    = en_q;
  assign bus.red_sew   = sew_q;
  assign bus.red_opSel = op_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
endmodule

// File: tb/tb_vred_seq_ctrl.sv
// Scoreboard bench: stimulus pushes expected scalars, a negedge monitor pops on each output handshake.
module tb_vred_seq_ctrl;
  localparam int DW = 32, RW = 64, OW = 9, SW = 2, L = 2;
  localparam logic [8:0] OP_SUM = 9'h000;
  localparam logic [8:0] OP_MAX = 9'h004;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vred_seq_ctrl_if #(.REQ_DATA_WIDTH(DW), .RESP_DATA_WIDTH(RW), .OPSEL_WIDTH(OW), .SEW_WIDTH(SW)) bus ();

  vred_seq_ctrl #(.REQ_DATA_WIDTH(DW), .RESP_DATA_WIDTH(RW), .OPSEL_WIDTH(OW), .SEW_WIDTH(SW),
                  .RED_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    int          pulses;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  logic        prev_en = 1'b0;
  logic [1:0]  cur_sew = 2'd2;
  logic [8:0]  cur_op = OP_SUM;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Behavioural reduction unit: lane-wise unsigned sum (wrapping) or max.
  function automatic logic [31:0] red_f(input logic [31:0] up, input logic [31:0] ac,
                                        input logic [1:0] sew, input logic [8:0] op);
    int          sb;
    logic [63:0] m, a, b, x;
    logic [31:0] r;
    sb = (sew == 2'd0) ? 8 : (sew == 2'd1) ? 16 : 32;
    m  = (64'd1 << sb) - 64'd1;
    r  = '0;
    for (int l = 0; l < 32 / sb; l++) begin
      a = (64'(ac) >> (l * sb)) & m;
      b = (64'(up) >> (l * sb)) & m;
      x = op[2] ? ((a > b) ? a : b) : ((a + b) & m);
      r = r | 32'(x << (l * sb));
    end
    return r;
  endfunction

  // Result is valid only in the cycle after red_en; other cycles carry junk.
  logic [63:0] pipe;
  logic        pipe_vld;
  always @(posedge clk) begin
    pipe_vld <= bus.red_en;
    pipe     <= {32'hA5A5_A5A5, red_f(bus.red_vec0[63:32], bus.red_vec0[31:0], bus.red_sew, bus.red_opSel)};
  end
  assign bus.red_result = pipe_vld ? pipe : 64'hDEAD_BEEF_0BAD_F00D;

  always @(negedge clk) begin
    if (rst) begin
      en_cnt  = 0;
      prev_en = 1'b0;
    end else begin
      if (bus.red_en) begin
        en_cnt++;
        check("red_en_back_to_back", 64'(prev_en), 64'd0);
        check("red_sew", 64'(bus.red_sew), 64'(cur_sew));
        check("red_opSel", 64'(bus.red_opSel), 64'(cur_op));
      end
      prev_en = bus.red_en;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(bus.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          check("red_en_pulses", 64'(en_cnt), 64'(e.pulses));
          en_cnt = 0;
        end
      end
    end
  end

  task automatic expect_result(input logic [31:0] d, input int pulses);
    exp_t e;
    e.data   = d;
    e.pulses = pulses;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [1:0] sew, input logic [8:0] op);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_sew   = sew;
    bus.in_opSel = op;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_red_en"}, 64'(bus.red_en), 64'd0);
    check({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    check({tag, "_red_vec0"}, bus.red_vec0, 64'd0);
    check({tag, "_red_sew"}, 64'(bus.red_sew), 64'd0);
    check({tag, "_red_opSel"}, 64'(bus.red_opSel), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.in_sew = '0; bus.in_opSel = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_red_en", 64'(bus.red_en), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");
    @(posedge clk); #1;

    // SEW=32 sum; later-word sew/opSel changes must be ignored.
    cur_sew = 2'd2; cur_op = OP_SUM;
    expect_result(32'd35, 2);
    send(32'd5, 1'b0, 2'd2, OP_SUM);
    send(32'd10, 1'b0, 2'd0, OP_MAX);
    send(32'd20, 1'b1, 2'd1, OP_MAX);
    drain();

    // SEW=8 single word: two folds, 1+2+3+4.
    cur_sew = 2'd0; cur_op = OP_SUM;
    expect_result(32'h0000_000A, 2);
    send(32'h0403_0201, 1'b1, 2'd0, OP_SUM);
    drain();

    // SEW=8 wrap: 0xFF + 0x01 = 0.
    expect_result(32'h0000_0000, 3);
    send(32'h0000_00FF, 1'b0, 2'd0, OP_SUM);
    send(32'h0000_0001, 1'b1, 2'd0, OP_SUM);
    drain();

    // SEW=16 max: lanes {9,7} fold to 9.
    cur_sew = 2'd1; cur_op = OP_MAX;
    expect_result(32'h0000_0009, 2);
    send(32'h0007_0003, 1'b0, 2'd1, OP_MAX);
    send(32'h0002_0009, 1'b1, 2'd1, OP_MAX);
    drain();

    // Output backpressure in DONE.
    cur_sew = 2'd2; cur_op = OP_SUM;
    bus.out_ready = 1'b0;
    expect_result(32'd42, 0);
    send(32'd42, 1'b1, 2'd2, OP_SUM);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) check("bp_valid_timeout", 64'(seen), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data", 64'(bus.out_data), 64'd42);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_after_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset while WAIT has a result pending, then a fresh reduction.
    send(32'd100, 1'b0, 2'd2, OP_SUM);
    send(32'd7, 1'b0, 2'd2, OP_SUM);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_wait");
    @(posedge clk); #1;
    expect_result(32'd3, 1);
    send(32'd1, 1'b0, 2'd2, OP_SUM);
    send(32'd2, 1'b1, 2'd2, OP_SUM);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
